out_channel_arbiter: RTL
========================

Name: out_channel_arbiter

Overview:
- Shares one out channel (output memory plus write position) between NReq program-execution requesters, e.g. several test-program engines running in one fpga build.
- Round-robin arbitration with a valid/ready handshake per requester; at most one element is appended per clock.
- Keeps the out memory, current position, full/sealed status and a rejected-request counter.
- Provides a registered read port so the success checker can inspect entries after the program finishes.

Parameters:
- MemoryElementWidth, 12, width of each out element in bits.
- NOut, 3, number of out memory entries; must be ≥1.
- NReq, 2, number of requesters; must be 2..8.
- PosWidth, $clog2(NOut+1), width of the position counter; derived, do not override.

Ports:
- clock  input  1  driving clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; restarts the channel.
- req_valid  input  NReq  bit i high: requester i offers req_data slice i.
- req_data  input  NReq*MemoryElementWidth  slice i is bits [i*MemoryElementWidth +: MemoryElementWidth].
- req_ready  output  NReq  bit i high: requester i's offer is accepted this cycle (combinational).
- seal  input  1  closes the channel; no further appends.
- rd_addr  input  PosWidth  read address for checking.
- rd_data  output  MemoryElementWidth  registered out memory[rd_addr], one-cycle latency.
- out_pos  output  PosWidth  number of elements written so far.
- last_grant  output  $clog2(NReq) (min 1)  index of the most recently accepted requester.
- full  output  1  high when out_pos == NOut.
- finished  output  1  high in SEALED state.
- rejected  output  16  count of cycles where any req_valid is high while no accept is possible; saturates at 16'hFFFF.

Behaviour:
- Reset, applied at the clock edge:
  - out_pos=0, last_grant=NReq-1 so that requester 0 has first priority.
  - full=0, finished=0, rejected=0, rd_data=0, state RUN.
  - Memory contents are not cleared.
  - Reset overrides every other input in the same cycle, including mid-operation and in SEALED.
- States:
  - RUN: accepting appends.
  - FULL: out_pos==NOut; no appends.
  - SEALED: terminal until reset.
- Transitions:
  - RUN→SEALED when seal=1. Seal has priority; no append occurs in that cycle.
  - RUN→FULL when an append makes out_pos==NOut.
  - FULL→SEALED when seal=1.
  - SEALED stays SEALED.
- Arbitration, combinational, in RUN only:
  - Search requesters in order last_grant+1, last_grant+2, … modulo NReq.
  - The first one with req_valid=1 is granted.
  - req_ready is one-hot on the granted index, all zero otherwise.
  - req_ready is all zero in FULL, SEALED, during reset, and when seal=1.
- Transfer when req_valid[i] and req_ready[i], at the clock edge:
  - mem[out_pos] ← slice i.
  - out_pos ← out_pos+1.
  - last_grant ← i.
- Exactly one transfer per cycle at most.
- Requesters must hold valid and data stable until ready; the arbiter does not latch unaccepted offers.
- rejected increments in any cycle where |req_valid is high and no transfer occurs because of FULL, SEALED or seal=1. Ordinary arbitration losers do not count.
- full is derived from state, so it reflects out_pos==NOut.
- finished is derived from state==SEALED.
- rd_data ← mem[rd_addr] each cycle.
  - If rd_addr ≥ NOut, rd_data ← 0.
  - Reading the address being written in the same cycle returns the old contents.
- A write and a read of different addresses in the same cycle are independent.
- No wrap-around: out_pos never exceeds NOut.

Test Plan:
- Reset, then req_valid=2'b01 with data 1, 2, 3 on three consecutive cycles (NOut=3, NReq=2):
  - req_ready[0] high each cycle; out_pos goes 1, 2, 3; full=1 after the third edge.
  - Reading addresses 0..2 returns 1, 2, 3, each one cycle after the address is applied.
- Both requesters valid continuously, req0 data=10, req1 data=20, NOut=3:
  - Grants alternate req0, req1, req0; memory holds 10, 20, 10; last_grant=0.
- Channel full, req_valid=2'b11 held for 4 cycles:
  - req_ready=0 throughout; rejected=4; out_pos stays 3; memory unchanged.
- After one append (out_pos=1), seal=1 together with req_valid[1]=1, data 7:
  - No write; rejected=1; finished=1 next cycle and stays high.
  - out_pos=1; rd_addr=1 returns the unwritten (pre-existing) contents.
- Reset asserted while valid requests are pending mid-stream:
  - out_pos=0, full=0, finished=0, rejected=0, last_grant=NReq-1.
  - The next accept goes to requester 0 when both requesters are valid.
- rd_addr=3 with NOut=3:
  - rd_data=0 one cycle later.

Source files
------------

// File: rtl/out_channel_arbiter.sv
// Round-robin arbiter sharing one append-only out memory among NReq requesters,
// with run/full/sealed status, a rejected-offer counter and a registered read port.
module out_channel_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 3,
  parameter int NReq = 2,
  parameter int PosWidth = $clog2(NOut + 1),
  localparam int LgWidth = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    req_valid,
  input  logic [NReq*MemoryElementWidth-1:0] req_data,
  output logic [NReq-1:0]                    req_ready,
  input  logic                               seal,
  input  logic [PosWidth-1:0]                rd_addr,
  output logic [MemoryElementWidth-1:0]      rd_data,
  output logic [PosWidth-1:0]                out_pos,
  output logic [LgWidth-1:0]                 last_grant,
  output logic                               full,
  output logic                               finished,
  output logic [15:0]                        rejected
);

  localparam int AddrWidth = (NOut > 1) ? $clog2(NOut) : 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FULL   = 2'd1;
  localparam logic [1:0] ST_SEALED = 2'd2;

  logic [1:0]                    state_reg, state_next;
  logic [PosWidth-1:0]           out_pos_reg, out_pos_next;
  logic [LgWidth-1:0]            last_grant_reg, last_grant_next;
  logic [15:0]                   rejected_reg, rejected_next;
  logic [MemoryElementWidth-1:0] rd_data_reg;
  logic [MemoryElementWidth-1:0] mem [NOut];

  logic                          grant_found;
  logic [LgWidth-1:0]            grant_idx;
  logic [MemoryElementWidth-1:0] grant_data;
  logic                          accept_ok;
  logic                          transfer;
  logic                          blocked_offer;
  int                            cand;

  // Search starts just after the previous winner, so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    cand        = 0;
    for (int k = 1; k <= NReq; k++) begin
      cand = (int'(last_grant_reg) + k) % NReq;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = LgWidth'(cand);
        grant_data  = req_data[cand*MemoryElementWidth +: MemoryElementWidth];
      end
    end
  end

  assign accept_ok     = (state_reg == ST_RUN) && !seal && !reset;
  assign transfer      = accept_ok && grant_found;
  assign req_ready     = transfer ? (NReq'(1) << grant_idx) : '0;
  assign blocked_offer = (|req_valid) && !transfer && ((state_reg != ST_RUN) || seal);

  always_comb begin
    state_next      = state_reg;
    out_pos_next    = out_pos_reg;
    last_grant_next = last_grant_reg;
    rejected_next   = rejected_reg;
    case (state_reg)
      ST_RUN: begin
        if (seal) begin
          state_next = ST_SEALED;
        end else if (transfer && (out_pos_reg == PosWidth'(NOut - 1))) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (seal) state_next = ST_SEALED;
      end
      default: state_next = ST_SEALED;
    endcase
    if (transfer) begin
      out_pos_next    = out_pos_reg + 1'b1;
      last_grant_next = grant_idx;
    end
    if (blocked_offer && (rejected_reg != 16'hFFFF)) begin
      rejected_next = rejected_reg + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      out_pos_reg    <= '0;
      last_grant_reg <= LgWidth'(NReq - 1);
      rejected_reg   <= '0;
      rd_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      out_pos_reg    <= out_pos_next;
      last_grant_reg <= last_grant_next;
      rejected_reg   <= rejected_next;
      if (int'(rd_addr) < NOut) begin
        rd_data_reg <= mem[rd_addr[AddrWidth-1:0]];
      end else begin
        rd_data_reg <= '0;
      end
    end
  end

  // Memory contents survive reset; only the write pointer is cleared.
  always_ff @(posedge clock) begin
    if (transfer) begin
      mem[out_pos_reg[AddrWidth-1:0]] <= grant_data;
    end
  end

  assign rd_data    = rd_data_reg;
  assign out_pos    = out_pos_reg;
  assign last_grant = last_grant_reg;
  assign rejected   = rejected_reg;
  assign full       = (state_reg == ST_FULL);
  assign finished   = (state_reg == ST_SEALED);

endmodule
